// File: rtl/msrh_lsu_pkg.sv
// Shared LSU pipe arbitration constants and helpers.
package msrh_lsu_pkg;

    // Requester slots of the per-pipe arbiter; lower index = higher static priority
    localparam int REQ_NUM       = 3;
    localparam int LSU_ARB_LDQ   = 0;
    localparam int LSU_ARB_STQ   = 1;
    localparam int LSU_ARB_ISSUE = 2;

    typedef logic [REQ_NUM-1:0] lsu_arb_oh_t;

    // Isolate the lowest set bit (zero in, zero out); callers truncate to their width
    function automatic logic [31:0] bit_extract_lsb(input logic [31:0] in);
        return in & (~in + 32'd1);
    endfunction

endpackage

// File: rtl/msrh_lsu_pipe_arbiter_if.sv
// Request/grant and pipeline-entry signals of one LSU pipe arbiter.
interface msrh_lsu_pipe_arbiter_if #(
    parameter int REQ_NUM   = 3,
    parameter int PAYLOAD_W = 64
);
    logic [REQ_NUM-1:0]   req_valid;
    logic [PAYLOAD_W-1:0] req_payload [REQ_NUM];
    logic [REQ_NUM-1:0]   req_ready;
    logic                 pipe_valid;
    logic [PAYLOAD_W-1:0] pipe_payload;
    logic [REQ_NUM-1:0]   pipe_src_oh;
    logic                 pipe_stall;
    logic                 flush;
    logic                 starve_event;

    // Requesters and pipeline side
    modport master (
        output req_valid, req_payload, pipe_stall, flush,
        input  req_ready, pipe_valid, pipe_payload, pipe_src_oh, starve_event
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_payload, pipe_stall, flush,
        output req_ready, pipe_valid, pipe_payload, pipe_src_oh, starve_event
    );
endinterface

// File: rtl/msrh_lsu_starve_cnt.sv
// Saturating starvation counter: clear beats increment, otherwise hold.
module msrh_lsu_starve_cnt #(
    parameter  int STARVE_MAX = 8,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge i_clk) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;
    assign o_sat = (cnt_q == MAX);
endmodule

// File: rtl/msrh_lsu_pipe_arbiter.sv
// One LSU pipe entry slot shared by LDQ replay, STQ replay and fresh issue.
// Static priority by index, overridden by requesters that have lost STARVE_MAX
// accept cycles in a row; winner lands in a one-deep register feeding EX0.
module msrh_lsu_pipe_arbiter #(
    parameter int REQ_NUM    = 3,
    parameter int PAYLOAD_W  = 64,
    parameter int STARVE_MAX = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    msrh_lsu_pipe_arbiter_if.slave arb
);
    import msrh_lsu_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [REQ_NUM-1:0][CNT_W-1:0] starve_cnt;
    logic [REQ_NUM-1:0]            starve_sat;
    logic [REQ_NUM-1:0]            urgent;
    logic [REQ_NUM-1:0]            winner;
    logic [REQ_NUM-1:0]            grant;
    logic [REQ_NUM-1:0]            cnt_clear;
    logic [REQ_NUM-1:0]            cnt_inc;
    logic                          accept;

    logic                 pipe_valid_d,   pipe_valid_q;
    logic [PAYLOAD_W-1:0] pipe_payload_d, pipe_payload_q;
    logic [REQ_NUM-1:0]   pipe_src_oh_d,  pipe_src_oh_q;

    // Slot can take a new entry when empty or draining; flush and reset block grants
    always_comb begin
        accept = !i_reset && !arb.flush && (!pipe_valid_q || !arb.pipe_stall);
        urgent = starve_sat & arb.req_valid;
        if (|urgent) winner = REQ_NUM'(bit_extract_lsb(32'(urgent)));
        else         winner = REQ_NUM'(bit_extract_lsb(32'(arb.req_valid)));
        grant  = accept ? winner : '0;
    end

    // Per-requester counter control; a stalled cycle (accept=0) is not a loss
    always_comb begin
        cnt_clear = {REQ_NUM{arb.flush}} | grant | ~arb.req_valid;
        cnt_inc   = arb.req_valid & ~grant & {REQ_NUM{accept}};
    end

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_cnt
        msrh_lsu_starve_cnt #(
            .STARVE_MAX (STARVE_MAX)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_clear (cnt_clear[g]),
            .i_inc   (cnt_inc[g]),
            .o_cnt   (starve_cnt[g]),
            .o_sat   (starve_sat[g])
        );
    end

    // Output register next state: flush drops, grant loads, empty accept drains, stall holds
    always_comb begin
        pipe_valid_d   = pipe_valid_q;
        pipe_payload_d = pipe_payload_q;
        pipe_src_oh_d  = pipe_src_oh_q;
        if (arb.flush) begin
            pipe_valid_d  = 1'b0;
            pipe_src_oh_d = '0;
        end else if (|grant) begin
            pipe_valid_d  = 1'b1;
            pipe_src_oh_d = grant;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (grant[i]) pipe_payload_d = arb.req_payload[i];
            end
        end else if (accept) begin
            pipe_valid_d  = 1'b0;
            pipe_src_oh_d = '0;
        end
    end

    // Output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pipe_valid_q   <= 1'b0;
            pipe_payload_q <= '0;
            pipe_src_oh_q  <= '0;
        end else begin
            pipe_valid_q   <= pipe_valid_d;
            pipe_payload_q <= pipe_payload_d;
            pipe_src_oh_q  <= pipe_src_oh_d;
        end
    end

    // Drive interface outputs
    always_comb begin
        arb.req_ready    = grant;
        arb.starve_event = accept && (|urgent);
        arb.pipe_valid   = pipe_valid_q;
        arb.pipe_payload = pipe_payload_q;
        arb.pipe_src_oh  = pipe_src_oh_q;
    end
endmodule

// File: tb/tb_msrh_lsu_pipe_arbiter.sv
// Scenario bench for msrh_lsu_pipe_arbiter: tasks push expected pipe entries
// when they see a grant; a negedge monitor pops them when the entry appears.
module tb_msrh_lsu_pipe_arbiter;
    localparam int RN = 3;
    localparam int PW = 64;
    localparam int SM = 8;

    typedef struct packed {
        logic [PW-1:0] payload;
        logic [RN-1:0] src;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    logic xfer_prev = 1'b0;

    msrh_lsu_pipe_arbiter_if #(.REQ_NUM(RN), .PAYLOAD_W(PW)) arb ();

    msrh_lsu_pipe_arbiter #(.REQ_NUM(RN), .PAYLOAD_W(PW), .STARVE_MAX(SM)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .arb     (arb)
    );

    always #5 clk = ~clk;

    // Scoreboard: an entry granted in cycle N must be on o_pipe_* in cycle N+1
    always @(negedge clk) begin
        if (xfer_prev) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got payload %h src %b, want no transfer", arb.pipe_payload, arb.pipe_src_oh);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (arb.pipe_valid !== 1'b1 || arb.pipe_payload !== e.payload || arb.pipe_src_oh !== e.src)
                    $display("FAIL sb_entry: got v=%b %h src %b, want v=1 %h src %b",
                             arb.pipe_valid, arb.pipe_payload, arb.pipe_src_oh, e.payload, e.src);
                else n_pass++;
            end
        end
        xfer_prev <= |(arb.req_valid & arb.req_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pay(input int k);
        for (int i = 0; i < RN; i++) arb.req_payload[i] = {32'(i + 1), 32'(k)};
    endtask

    task automatic expect_grant(input logic [RN-1:0] want, input string name);
        n_total++;
        if (arb.req_ready !== want) $display("FAIL %s: ready %b, want %b", name, arb.req_ready, want);
        else n_pass++;
        for (int i = 0; i < RN; i++)
            if (want[i]) sb_q.push_back('{payload: arb.req_payload[i], src: want});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arb.req_valid = 3'b111;
        arb.pipe_stall = 1'b0;
        arb.flush = 1'b0;
        set_pay(0);
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (arb.pipe_valid !== 1'b0 || arb.pipe_payload !== '0 || arb.pipe_src_oh !== '0)
                $display("FAIL reset_pipe: v=%b %h src %b, want 0", arb.pipe_valid, arb.pipe_payload, arb.pipe_src_oh);
            else n_pass++;
            n_total++;
            if (arb.req_ready !== '0 || arb.starve_event !== 1'b0 || dut.starve_cnt !== '0)
                $display("FAIL reset_ctl: ready %b ev %b cnt %h, want 0", arb.req_ready, arb.starve_event, dut.starve_cnt);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        @(negedge clk);
        expect_grant(3'b001, "first_grant");
        tick();
        arb.req_valid = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_starvation();
        arb.req_valid = 3'b101;
        for (int k = 1; k <= 9; k++) begin
            set_pay(100 + k);
            @(negedge clk);
            n_total++;
            if (dut.starve_cnt[2] !== 4'(k - 1)) $display("FAIL starve_cnt_k%0d: cnt %0d, want %0d", k, dut.starve_cnt[2], k - 1);
            else n_pass++;
            expect_grant((k == 9) ? 3'b100 : 3'b001, "starve_grant");
            n_total++;
            if (arb.starve_event !== (k == 9)) $display("FAIL starve_event_k%0d: got %b, want %b", k, arb.starve_event, k == 9);
            else n_pass++;
            tick();
        end
        set_pay(110);
        @(negedge clk);
        n_total++;
        if (dut.starve_cnt[2] !== 4'd0) $display("FAIL starve_clear: cnt %0d, want 0", dut.starve_cnt[2]);
        else n_pass++;
        expect_grant(3'b001, "starve_after");
        tick();
        arb.req_valid = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_stall();
        logic [PW-1:0] held;
        arb.req_valid = 3'b001;
        set_pay(200);
        held = arb.req_payload[0];
        @(negedge clk);
        expect_grant(3'b001, "stall_load");
        tick();
        arb.req_valid = 3'b010;
        arb.pipe_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_pay(210 + k);
            @(negedge clk);
            n_total++;
            if (arb.req_ready !== '0 || dut.starve_cnt[1] !== 4'd0)
                $display("FAIL stall_block_%0d: ready %b cnt %0d, want 0 0", k, arb.req_ready, dut.starve_cnt[1]);
            else n_pass++;
            n_total++;
            if (arb.pipe_valid !== 1'b1 || arb.pipe_payload !== held || arb.pipe_src_oh !== 3'b001)
                $display("FAIL stall_hold_%0d: v=%b %h src %b, want v=1 %h src 001", k, arb.pipe_valid, arb.pipe_payload, arb.pipe_src_oh, held);
            else n_pass++;
            tick();
        end
        arb.pipe_stall = 1'b0;
        @(negedge clk);
        expect_grant(3'b010, "stall_release");
        tick();
        arb.req_valid = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_flush();
        arb.req_valid = 3'b011;
        for (int k = 0; k < 3; k++) begin
            set_pay(300 + k);
            @(negedge clk);
            expect_grant(3'b001, "flush_pre");
            tick();
        end
        arb.flush = 1'b1;
        set_pay(310);
        @(negedge clk);
        n_total++;
        if (arb.req_ready !== '0 || arb.starve_event !== 1'b0)
            $display("FAIL flush_grant: ready %b ev %b, want 0 0", arb.req_ready, arb.starve_event);
        else n_pass++;
        tick();
        arb.flush = 1'b0;
        arb.req_valid = '0;
        @(negedge clk);
        n_total++;
        if (arb.pipe_valid !== 1'b0 || arb.pipe_src_oh !== '0 || dut.starve_cnt !== '0)
            $display("FAIL flush_state: v=%b src %b cnt %h, want 0", arb.pipe_valid, arb.pipe_src_oh, dut.starve_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        arb.req_valid = 3'b100;
        for (int k = 1; k <= 4; k++) begin
            set_pay(400 + k);
            @(negedge clk);
            expect_grant(3'b100, "b2b_grant");
            if (k >= 2) begin
                n_total++;
                if (arb.pipe_valid !== 1'b1) $display("FAIL b2b_valid_c%0d: got %b, want 1", k, arb.pipe_valid);
                else n_pass++;
            end
            tick();
        end
        arb.req_valid = '0;
        @(negedge clk);
        n_total++;
        if (arb.pipe_valid !== 1'b1) $display("FAIL b2b_valid_c5: got %b, want 1", arb.pipe_valid);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if (arb.pipe_valid !== 1'b0) $display("FAIL b2b_drain: got %b, want 0", arb.pipe_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        arb.req_valid = 3'b011;
        for (int k = 0; k < 7; k++) begin
            set_pay(500 + k);
            @(negedge clk);
            expect_grant(3'b001, "rmid_pre");
            tick();
        end
        rst = 1'b1;
        arb.pipe_stall = 1'b1;
        @(negedge clk);
        n_total++;
        if (dut.starve_cnt[1] !== 4'd7 || arb.pipe_valid !== 1'b1 || arb.req_ready !== '0)
            $display("FAIL rmid_before: cnt %0d v=%b ready %b, want 7 1 000", dut.starve_cnt[1], arb.pipe_valid, arb.req_ready);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if (arb.pipe_valid !== 1'b0 || arb.pipe_payload !== '0 || dut.starve_cnt !== '0)
            $display("FAIL rmid_after: v=%b %h cnt %h, want 0", arb.pipe_valid, arb.pipe_payload, dut.starve_cnt);
        else n_pass++;
        tick();
        rst = 1'b0;
        arb.pipe_stall = 1'b0;
        arb.req_valid = '0;
        @(negedge clk);
        tick();
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_starvation();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d entries, want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
